// File: rtl/audio_net_pkg.sv
// Shared definitions for the network audio path.
// Holds the playback state encoding, the sample and byte widths, and a
// saturating increment used by the event counters.
package audio_net_pkg;

  localparam int SAMPLE_W = 16;
  localparam int BYTE_W   = 8;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic {
    BUFFER = 1'b0,
    PLAY   = 1'b1
  } play_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous single-clock sample FIFO with registered read data.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset (pointers only)
//   wr_en_i/wr_data_i write request and sample
//   rd_en_i           pop request; ignored when empty
//   rd_data_o         sample popped on the previous accepted read, held
//   full_o, empty_o   status
//   level_o           samples currently stored (0..2^ADDR_W)
// A write while full is accepted only if a pop happens in the same cycle.
module audio_sample_fifo
  import audio_net_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [SAMPLE_W-1:0] wr_data_i,
  input  logic                rd_en_i,
  output logic [SAMPLE_W-1:0] rd_data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [ADDR_W:0]     level_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [SAMPLE_W-1:0] rd_data_q;
  logic [ADDR_W:0]     wr_ptr_q, rd_ptr_q;
  logic                do_wr, do_rd;

  assign level_o = wr_ptr_q - rd_ptr_q;
  // Level can only reach 2^ADDR_W when full, so the top bit is the full flag.
  assign full_o  = level_o[ADDR_W];
  assign empty_o = (level_o == '0);
  assign do_rd   = rd_en_i && !empty_o;
  assign do_wr   = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = rd_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // At full with a simultaneous pop both address the same slot; the read
  // returns the old head before the write replaces it.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
    if (do_rd) rd_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
  end

endmodule

// File: rtl/udp_audio_depacketizer.sv
// UDP payload to PCM playback path.
// Assembles received payload bytes into 16-bit samples, buffers them in a
// jitter FIFO and hands one sample to the codec driver per wav_rden.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   udp_rec_data_valid/_rdata     one payload byte per cycle while valid
//   udp_rec_data_length           payload length, latched at packet start
//   wav_rden                      single-cycle playback request
//   wav_out_data                  sample for the codec, held between requests
//   play_active                   high while playing (not refilling)
//   fifo_level                    samples buffered
//   underflow_cnt, overflow_cnt   saturating event counters
module udp_audio_depacketizer
  import audio_net_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int PREFILL    = 64,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                udp_rec_data_valid,
  input  logic [BYTE_W-1:0]   udp_rec_rdata,
  input  logic [15:0]         udp_rec_data_length,
  input  logic                wav_rden,
  output logic [SAMPLE_W-1:0] wav_out_data,
  output logic                play_active,
  output logic [ADDR_W:0]     fifo_level,
  output logic [15:0]         underflow_cnt,
  output logic [15:0]         overflow_cnt
);

  localparam logic [ADDR_W:0] PREFILL_L = (ADDR_W+1)'(PREFILL);

  logic                in_pkt_q, in_pkt_d;
  logic                phase_q, phase_d;
  logic [BYTE_W-1:0]   hold_q, hold_d;
  logic [15:0]         cnt_q, cnt_d, cnt_inc;
  logic [15:0]         len_q, len_d, len_cur;
  play_state_e         state_q, state_d;
  logic                zero_q, zero_d;
  logic [15:0]         unf_q, unf_d, ovf_q, ovf_d;
  logic                wr_en, fifo_rd, fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] wr_data, fifo_rd_data;

  // Byte assembly: a packet ends on reaching the latched length (if
  // nonzero) or on any idle cycle; either way phase returns to 0 so an odd
  // trailing byte is dropped and the next byte starts a fresh packet.
  always_comb begin
    in_pkt_d = in_pkt_q;
    phase_d  = phase_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    len_cur  = len_q;
    cnt_inc  = '0;
    wr_en    = 1'b0;
    wr_data  = '0;
    if (udp_rec_data_valid) begin
      len_cur = in_pkt_q ? len_q : udp_rec_data_length;
      cnt_inc = (in_pkt_q ? cnt_q : 16'd0) + 16'd1;
      len_d   = len_cur;
      if (phase_q) begin
        wr_en   = 1'b1;
        wr_data = BIG_ENDIAN ? {hold_q, udp_rec_rdata} : {udp_rec_rdata, hold_q};
        phase_d = 1'b0;
      end else begin
        hold_d  = udp_rec_rdata;
        phase_d = 1'b1;
      end
      if ((len_cur != 16'd0) && (cnt_inc == len_cur)) begin
        in_pkt_d = 1'b0;
        phase_d  = 1'b0;
        cnt_d    = '0;
      end else begin
        in_pkt_d = 1'b1;
        cnt_d    = cnt_inc;
      end
    end else begin
      in_pkt_d = 1'b0;
      phase_d  = 1'b0;
      cnt_d    = '0;
    end
  end

  // Playback FSM. zero_q selects silence on the output instead of the FIFO
  // read register, so the output holds whichever was chosen last.
  always_comb begin
    state_d = state_q;
    zero_d  = zero_q;
    unf_d   = unf_q;
    fifo_rd = 1'b0;
    case (state_q)
      BUFFER: begin
        if (wav_rden) zero_d = 1'b1;
        if (fifo_level >= PREFILL_L) state_d = PLAY;
      end
      PLAY: begin
        if (wav_rden) begin
          if (!fifo_empty) begin
            fifo_rd = 1'b1;
            zero_d  = 1'b0;
          end else begin
            zero_d  = 1'b1;
            unf_d   = sat_inc(unf_q);
            state_d = BUFFER;
          end
        end
      end
      default: state_d = BUFFER;
    endcase
  end

  // A same-cycle pop frees the slot, so only a write at full without a pop
  // is a drop.
  assign ovf_d = (wr_en && fifo_full && !fifo_rd) ? sat_inc(ovf_q) : ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_pkt_q <= 1'b0;
      phase_q  <= 1'b0;
      cnt_q    <= '0;
      len_q    <= '0;
      state_q  <= BUFFER;
      zero_q   <= 1'b1;
      unf_q    <= '0;
      ovf_q    <= '0;
    end else begin
      in_pkt_q <= in_pkt_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      state_q  <= state_d;
      zero_q   <= zero_d;
      unf_q    <= unf_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  audio_sample_fifo #(.ADDR_W(ADDR_W)) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign wav_out_data  = zero_q ? '0 : fifo_rd_data;
  assign play_active   = (state_q == PLAY);
  assign underflow_cnt = unf_q;
  assign overflow_cnt  = ovf_q;

endmodule

// File: tb/tb_udp_audio_depacketizer.sv
// Bench for udp_audio_depacketizer: directed packets and playback requests,
// a queue-based reference model compared every cycle, and literal checks.
module tb_udp_audio_depacketizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v = 1'b0;
  logic [7:0]  b = 8'h00;
  logic [15:0] len = 16'h0;
  logic        rd = 1'b0;
  logic [15:0] out, unf, ovf;
  logic        play;
  logic [9:0]  lvl;

  logic        le_v = 1'b0;
  logic [7:0]  le_b = 8'h00;
  logic [15:0] le_len = 16'h0;
  logic        le_rd = 1'b0;
  logic [15:0] le_out, le_unf, le_ovf;
  logic        le_play;
  logic [9:0]  le_lvl;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  udp_audio_depacketizer #(.ADDR_W(9), .PREFILL(64), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .udp_rec_data_valid(v), .udp_rec_rdata(b), .udp_rec_data_length(len),
    .wav_rden(rd), .wav_out_data(out), .play_active(play),
    .fifo_level(lvl), .underflow_cnt(unf), .overflow_cnt(ovf)
  );

  udp_audio_depacketizer #(.ADDR_W(9), .PREFILL(1), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst),
    .udp_rec_data_valid(le_v), .udp_rec_rdata(le_b), .udp_rec_data_length(le_len),
    .wav_rden(le_rd), .wav_out_data(le_out), .play_active(le_play),
    .fifo_level(le_lvl), .underflow_cnt(le_unf), .overflow_cnt(le_ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: packets as byte streams, FIFO as a queue.
  logic [15:0] mq[$];
  bit          m_play = 1'b0, m_nplay = 1'b0;
  bit          m_inpkt = 1'b0, m_phase = 1'b0, m_wr = 1'b0;
  logic [7:0]  m_hold = 8'h00;
  logic [15:0] m_ws = 16'h0;
  int          m_cnt = 0, m_len = 0, m_pre = 0;
  logic [15:0] m_out = 16'h0, m_unf = 16'h0, m_ovf = 16'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_play = 1'b0; m_inpkt = 1'b0; m_phase = 1'b0;
      m_cnt = 0; m_len = 0;
      m_out = 16'h0; m_unf = 16'h0; m_ovf = 16'h0;
    end else begin
      m_pre = mq.size();
      m_wr = 1'b0;
      if (v) begin
        if (!m_inpkt) begin
          m_inpkt = 1'b1; m_cnt = 0; m_len = int'(len); m_phase = 1'b0;
        end
        if (m_phase) begin
          m_ws = {m_hold, b}; m_wr = 1'b1; m_phase = 1'b0;
        end else begin
          m_hold = b; m_phase = 1'b1;
        end
        m_cnt++;
        if (m_len != 0 && m_cnt == m_len) begin
          m_inpkt = 1'b0; m_phase = 1'b0;
        end
      end else begin
        m_inpkt = 1'b0; m_phase = 1'b0;
      end
      m_nplay = m_play;
      if (!m_play && m_pre >= 64) m_nplay = 1'b1;
      if (rd) begin
        if (!m_play) m_out = 16'h0;
        else if (m_pre > 0) m_out = mq.pop_front();
        else begin
          m_out = 16'h0;
          if (m_unf != 16'hFFFF) m_unf++;
          m_nplay = 1'b0;
        end
      end
      if (m_wr) begin
        if (mq.size() < 512) mq.push_back(m_ws);
        else if (m_ovf != 16'hFFFF) m_ovf++;
      end
      m_play = m_nplay;
    end
  end

  always @(negedge clk) begin
    chk("model_out", 32'(out), 32'(m_out));
    chk("model_play", 32'(play), 32'(m_play));
    chk("model_level", 32'(lvl), 32'(mq.size()));
    chk("model_unf", 32'(unf), 32'(m_unf));
    chk("model_ovf", 32'(ovf), 32'(m_ovf));
  end

  task automatic cyc(input bit vv, input logic [7:0] bb, input logic [15:0] ll, input bit rr);
    @(posedge clk); #1;
    v = vv; b = bb; len = ll; rd = rr;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 16'h0, 1'b0);
  endtask

  task automatic pop_once();
    cyc(1'b0, 8'h00, 16'h0, 1'b1);
    cyc(1'b0, 8'h00, 16'h0, 1'b0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_out"}, 32'(out), 32'h0);
    chk({nm, "_play"}, 32'(play), 32'h0);
    chk({nm, "_level"}, 32'(lvl), 32'h0);
    chk({nm, "_unf"}, 32'(unf), 32'h0);
    chk({nm, "_ovf"}, 32'(ovf), 32'h0);
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    chk_all_zero("reset");

    // Little-endian instance: 34 12 -> 0x1234.
    @(posedge clk); #1; le_v = 1'b1; le_b = 8'h34; le_len = 16'd2;
    @(posedge clk); #1; le_b = 8'h12;
    @(posedge clk); #1; le_v = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    le_rd = 1'b1;
    @(posedge clk); #1; le_rd = 1'b0;
    chk("le_sample", 32'(le_out), 32'h1234);
    chk("le_level", 32'(le_lvl), 32'h0);
    chk("le_play", 32'(le_play), 32'h1);

    // 64 samples 0x0001..0x0040, big-endian, one 128-byte packet.
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, 8'((i + 1) >> 8), 16'd128, 1'b0);
      cyc(1'b1, 8'(i + 1), 16'd128, 1'b0);
    end
    idle(3);
    chk("prefill_level", 32'(lvl), 32'd64);
    chk("prefill_play", 32'(play), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      pop_once();
      chk("first_pops", 32'(out), 32'(i));
    end

    // Odd-length packet, immediately followed by a second packet.
    cyc(1'b1, 8'hAA, 16'd5, 1'b0);
    cyc(1'b1, 8'hBB, 16'd5, 1'b0);
    cyc(1'b1, 8'hCC, 16'd5, 1'b0);
    cyc(1'b1, 8'hDD, 16'd5, 1'b0);
    cyc(1'b1, 8'hEE, 16'd5, 1'b0);
    cyc(1'b1, 8'h11, 16'd2, 1'b0);
    cyc(1'b1, 8'h22, 16'd2, 1'b0);
    idle(3);
    chk("odd_pkt_level", 32'(lvl), 32'd59);

    // Fill past full: 456 samples into 453 free slots, length 0 packet.
    for (int j = 0; j < 456; j++) begin
      cyc(1'b1, 8'h40 | 8'(j >> 8), 16'd0, 1'b0);
      cyc(1'b1, 8'(j), 16'd0, 1'b0);
    end
    idle(3);
    chk("full_level", 32'(lvl), 32'd512);
    chk("full_ovf", 32'(ovf), 32'd3);

    // Write and pop in the same cycle at full.
    cyc(1'b1, 8'h5A, 16'd2, 1'b0);
    cyc(1'b1, 8'hA5, 16'd2, 1'b1);
    cyc(1'b0, 8'h00, 16'h0, 1'b0);
    chk("full_pop_out", 32'(out), 32'h0009);
    chk("full_pop_level", 32'(lvl), 32'd512);
    chk("full_pop_ovf", 32'(ovf), 32'd3);

    // Drain: spaced pops first, then back-to-back, then one on empty.
    for (int i = 0; i < 60; i++) begin
      pop_once();
      if (i == 55) chk("drain_aabb", 32'(out), 32'hAABB);
      if (i == 56) chk("drain_ccdd", 32'(out), 32'hCCDD);
      if (i == 57) chk("drain_1122", 32'(out), 32'h1122);
    end
    repeat (453) cyc(1'b0, 8'h00, 16'h0, 1'b1);
    cyc(1'b0, 8'h00, 16'h0, 1'b0);
    chk("underflow_out", 32'(out), 32'h0);
    chk("underflow_cnt", 32'(unf), 32'd1);
    chk("underflow_play", 32'(play), 32'h0);
    chk("underflow_level", 32'(lvl), 32'h0);

    // Refill: 63 samples stay in BUFFER, the 64th restarts playback.
    for (int i = 0; i < 63; i++) begin
      cyc(1'b1, 8'hC0, 16'd126, 1'b0);
      cyc(1'b1, 8'(i), 16'd126, 1'b0);
    end
    idle(4);
    chk("refill63_level", 32'(lvl), 32'd63);
    chk("refill63_play", 32'(play), 32'h0);
    pop_once();
    chk("buffer_rden_out", 32'(out), 32'h0);
    cyc(1'b1, 8'hC1, 16'd2, 1'b0);
    cyc(1'b1, 8'h3F, 16'd2, 1'b0);
    idle(3);
    chk("refill64_level", 32'(lvl), 32'd64);
    chk("refill64_play", 32'(play), 32'h1);

    // Reset in the middle of a packet.
    cyc(1'b1, 8'h01, 16'd8, 1'b0);
    cyc(1'b1, 8'h02, 16'd8, 1'b0);
    cyc(1'b1, 8'h03, 16'd8, 1'b0);
    cyc(1'b0, 8'h00, 16'h0, 1'b0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("in_reset");
    rst = 1'b0;
    #1 chk_all_zero("after_reset");
    cyc(1'b1, 8'h04, 16'd4, 1'b0);
    cyc(1'b1, 8'h05, 16'd4, 1'b0);
    cyc(1'b1, 8'h06, 16'd4, 1'b0);
    cyc(1'b1, 8'h07, 16'd4, 1'b0);
    idle(3);
    chk("post_reset_level", 32'(lvl), 32'd2);
    chk("post_reset_le_level", 32'(le_lvl), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_audio_depacketizer.md
# udp_audio_depacketizer

Receive-side audio path: takes the byte stream delivered by the UDP receive interface of the Ethernet core, reassembles 16-bit PCM samples, buffers them in a jitter FIFO, and supplies one sample per playback request from the WM8731 codec driver (`wav_out_data` / `wav_rden`). It is the counterpart of the capture packetizer that turns `wav_in_data` / `wav_wren` into UDP payloads, and sits between the Ethernet core and the codec driver in the top level.

## Interface
- `ADDR_W`, 9: FIFO address width; depth = 2^ADDR_W samples (512).
- `PREFILL`, 64: samples that must be buffered before playback starts or restarts; legal range 1..2^ADDR_W.
- `BIG_ENDIAN`, 1: 1 = first byte of each pair is the sample MSB (network order); 0 = LSB first.
- `clk`  in  1  system clock, 50 MHz domain shared with codec driver and UDP interface.
- `rst`  in  1  reset, asynchronous, active-high.
- `udp_rec_data_valid`  in  1  one received payload byte per cycle while high.
- `udp_rec_rdata`  in  8  payload byte.
- `udp_rec_data_length`  in  16  payload length in bytes, stable while the packet is delivered.
- `wav_rden`  in  1  single-cycle playback request from the codec driver.
- `wav_out_data`  out  16  sample to play, held between requests.
- `play_active`  out  1  high in PLAY state.
- `fifo_level`  out  ADDR_W+1  samples currently buffered.
- `underflow_cnt`  out  16  requests served with silence while in PLAY, saturating.
- `overflow_cnt`  out  16  samples dropped because FIFO was full, saturating.

## Operation
- Byte assembly: the packet starts on the first valid byte after an idle cycle; length latched then. Byte counter and phase bit advance per valid byte. Even-phase byte held; odd-phase byte completes a sample and issues one FIFO write.
- Packet end: byte count reaches the latched length, or `udp_rec_data_valid` low for one cycle, whichever is first. At packet end the phase resets; a held odd trailing byte is discarded. Latched length 0 means end only on valid deassert. Valid bytes beyond the latched length start a new packet.
- Overflow: write while full drops the sample and increments `overflow_cnt`; FIFO contents untouched.
- Playback FSM states: BUFFER (reset state) and PLAY.
  - BUFFER: `wav_rden` does not pop; `wav_out_data` loads 0. Go to PLAY when `fifo_level` ≥ PREFILL.
  - PLAY: `wav_rden` with FIFO non-empty pops and loads the head sample. `wav_rden` with FIFO empty loads 0, increments `underflow_cnt`, goes to BUFFER.
- Simultaneous write and pop in the same cycle: both occur; level unchanged; legal at full (pop frees the slot, write accepted, no overflow) and at empty (write not visible to that pop; underflow taken).
- Counters saturate at 16'hFFFF; cleared only by reset.
- Reset values: `wav_out_data` 0, `play_active` 0, `fifo_level` 0, both counters 0, FSM BUFFER, phase 0, byte counter 0. Reset mid-packet discards the partial packet; remaining bytes after reset release are treated as a new packet.

## Timing
- Input to FIFO: sample written on the clock edge that samples the odd byte; `fifo_level` reflects it the next cycle.
- Read latency: `wav_out_data` valid one cycle after `wav_rden`; held until the next request.
- BUFFER→PLAY: `play_active` rises the cycle after `fifo_level` first meets PREFILL; a `wav_rden` on that same cycle is still served as BUFFER (zero).
- Throughput: one byte per cycle in, one pop per cycle out; no backpressure toward the UDP interface.

## Structure
- Shared package `audio_net_pkg`: playback state enum (BUFFER, PLAY), sample width constant 16, byte width 8, saturating-counter max.
- Sub-module `audio_sample_fifo`: synchronous single-clock FIFO (ADDR_W, 16-bit data) with full, empty, level and registered read data; top block holds assembly logic, FSM and counters.

## Test plan
- Reset then 64-sample packet (128 bytes, 0x0001..0x0040, big-endian) -> `fifo_level`=64, `play_active` rises; eight `wav_rden` pulses return 0x0001..0x0008 one cycle after each request.
- 5-byte packet AA BB CC DD EE, length 5 -> two samples 0xAABB, 0xCCDD written; 0xEE dropped; next packet starts with phase 0.
- `BIG_ENDIAN`=0, bytes 34 12 -> sample 0x1234.
- Fill to 512, send 3 more samples -> `overflow_cnt`=3, level stays 512; full plus same-cycle write/pop -> write accepted, `overflow_cnt` unchanged.
- In PLAY, drain to empty, issue `wav_rden` -> `wav_out_data`=0, `underflow_cnt`=1, `play_active` low; 63 new samples keep BUFFER, 64th returns to PLAY.
- Assert `rst` after 3 bytes of a packet -> all outputs zero; after release, 4 more bytes produce exactly 2 samples.
